// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one acquisition into the circular trace RAM (prefill, arm, trigger, post).
// Build option: define CAPTURE_DECIMATE_EN to compile in the 16-bit sample prescaler.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int AW      = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_capture_go,
    input  logic [AW-1:0] i_trig_pos,
    input  logic          i_trig_in,
    input  logic [3:0]    i_decimator,
    input  logic          i_dump_busy,
    output logic          o_we,
    output logic          o_cap_en,
    output logic [AW-1:0] o_cap_addr,
    output logic [AW-1:0] o_trace_end,
    output logic          o_armed,
    output logic          o_triggered,
    output logic          o_capture_done,
    output logic [2:0]    o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);
    localparam logic [AW:0]   DEPTH     = (AW+1)'(ENTRIES);

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_sample_cnt;
    logic [AW-1:0] r_post_cnt;
    logic [AW-1:0] r_keep;

    logic          w_go;
    logic          w_tick;
    logic [AW-1:0] w_keep_clamped;
    logic [AW-1:0] w_ptr_inc;
    logic [AW-1:0] w_last_written;
    logic [AW:0]   w_prefill_target;

    // A start request is only honoured while the dump path does not own the RAM.
    assign w_go             = i_capture_go & ~i_dump_busy;
    assign w_keep_clamped   = ({1'b0, i_trig_pos} >= DEPTH) ? LAST_ADDR : i_trig_pos;
    assign w_ptr_inc        = (r_ptr == LAST_ADDR) ? '0 : r_ptr + AW'(1);
    assign w_last_written   = (r_ptr == '0) ? LAST_ADDR : r_ptr - AW'(1);
    assign w_prefill_target = DEPTH - {1'b0, r_keep};
    assign o_dbg_state      = r_state;

`ifdef CAPTURE_DECIMATE_EN
    logic [15:0] r_presc;
    logic [3:0]  r_dec;
    logic [15:0] w_presc_max;
    logic        w_capturing;

    assign w_capturing = (r_state == ST_PREFILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_presc_max = (16'd1 << r_dec) - 16'd1;
    assign w_tick      = (r_presc == w_presc_max);

    // The start edge itself is a sample; the prescaler then counts from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
            r_dec   <= '0;
        end else if (w_go) begin
            r_presc <= '0;
            r_dec   <= i_decimator;
        end else if (w_capturing) begin
            r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
        end
    end
`else
    logic w_unused_decimator;
    assign w_unused_decimator = ^i_decimator;
    assign w_tick             = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_sample_cnt   <= '0;
            r_post_cnt     <= '0;
            r_keep         <= '0;
            o_we           <= 1'b0;
            o_cap_en       <= 1'b0;
            o_cap_addr     <= '0;
            o_trace_end    <= '0;
            o_armed        <= 1'b0;
            o_triggered    <= 1'b0;
            o_capture_done <= 1'b0;
        end else begin
            o_cap_en <= 1'b0;
            if (w_go) begin
                r_state        <= ST_PREFILL;
                r_keep         <= w_keep_clamped;
                r_sample_cnt   <= (AW+1)'(1);
                r_post_cnt     <= '0;
                r_ptr          <= (ENTRIES > 1) ? AW'(1) : '0;
                o_cap_en       <= 1'b1;
                o_cap_addr     <= '0;
                o_we           <= 1'b1;
                o_armed        <= 1'b0;
                o_triggered    <= 1'b0;
                o_capture_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_PREFILL: begin
                        if (r_sample_cnt >= w_prefill_target) begin
                            r_state <= ST_ARMED;
                            o_armed <= 1'b1;
                        end
                        if (w_tick) begin
                            o_cap_en     <= 1'b1;
                            o_cap_addr   <= r_ptr;
                            r_ptr        <= w_ptr_inc;
                            r_sample_cnt <= r_sample_cnt + (AW+1)'(1);
                        end
                    end
                    ST_ARMED: begin
                        if (i_trig_in && (r_keep == '0)) begin
                            r_state        <= ST_DONE;
                            o_we           <= 1'b0;
                            o_armed        <= 1'b0;
                            o_capture_done <= 1'b1;
                            o_trace_end    <= w_last_written;
                        end else begin
                            if (i_trig_in) begin
                                r_state     <= ST_POST;
                                r_post_cnt  <= '0;
                                o_armed     <= 1'b0;
                                o_triggered <= 1'b1;
                            end
                            // The trigger cycle's own sample is written but not counted.
                            if (w_tick) begin
                                o_cap_en   <= 1'b1;
                                o_cap_addr <= r_ptr;
                                r_ptr      <= w_ptr_inc;
                            end
                        end
                    end
                    ST_POST: begin
                        if (r_post_cnt == r_keep) begin
                            r_state        <= ST_DONE;
                            o_we           <= 1'b0;
                            o_triggered    <= 1'b0;
                            o_capture_done <= 1'b1;
                            o_trace_end    <= w_last_written;
                        end else if (w_tick) begin
                            o_cap_en   <= 1'b1;
                            o_cap_addr <= r_ptr;
                            r_ptr      <= w_ptr_inc;
                            r_post_cnt <= r_post_cnt + AW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequences acquisition into the 384-entry circular trace RAM for the three capture channels. It runs one capture per `capture_go`: pre-trigger fill, arm, trigger, then post-trigger count. It drives the capture-side write enable/address consumed by the RAM interface and publishes `trace_end` so a later dump starts at the oldest sample. It sits between the command processor and trigger logic on one side and the trace RAM interface on the other.

## Interface
- `ENTRIES`, 384, trace RAM depth in samples
- `AW`, 9, address width
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `capture_go`  in  1  one-cycle pulse from command processor: start/restart capture
- `trig_pos`  in  AW  samples to keep after trigger; values ≥ ENTRIES clamp to ENTRIES-1
- `trig_in`  in  1  qualified trigger event (level or pulse; first high cycle counts)
- `decimator`  in  4  sample every 2^decimator clocks (see Configuration)
- `dump_busy`  in  1  dump in progress; RAM is owned by the dump path
- `we`  out  1  capture owns RAM (write mode select)
- `cap_en`  out  1  write strobe, one cycle per sample
- `cap_addr`  out  AW  write address
- `trace_end`  out  AW  address of newest sample of completed trace
- `armed`  out  1  high in ARMED
- `triggered`  out  1  high in POST
- `capture_done`  out  1  level, high in DONE

## Operation
- States: IDLE, PREFILL, ARMED, POST, DONE.
- IDLE → PREFILL on `capture_go` while `!dump_busy`. A `capture_go` with `dump_busy` high is dropped, state unchanged.
- Entry to PREFILL clears the write pointer to 0, the sample count, the post count and the prescaler.
- Sample tick:
  - Each tick in PREFILL/ARMED/POST writes one sample: `cap_en`=1, `cap_addr`=pointer.
  - The pointer then increments, wrapping ENTRIES-1 → 0.
- PREFILL → ARMED when the sample count reaches ENTRIES - trig_pos (clamped), so the pre-trigger history is valid.
  - `trig_in` is ignored in PREFILL.
- ARMED → POST on the first `trig_in` high.
  - Post count = 0.
  - The trigger cycle's own tick, if any, is still written and is not counted.
- POST counts ticks. At post count == trig_pos:
  - → DONE.
  - `trace_end` ← address of the last written sample.
- ARMED with trig_pos == 0: the trigger goes straight to DONE. `trace_end` ← last written address.
- DONE holds `capture_done`=1 and `we`=0 until the next accepted `capture_go`, which re-enters PREFILL.
- `capture_go` in PREFILL/ARMED/POST restarts: same clearing as from IDLE.
- `we`=1 in PREFILL, ARMED and POST; 0 otherwise.
- `dump_busy` rising mid-capture: no effect. Arbitration of `capture_go` is the only interlock.
- `trace_end` is only updated on entry to DONE; it keeps its old value otherwise.

## Timing
- Reset values:
  - state IDLE
  - `we`, `cap_en`, `armed`, `triggered`, `capture_done` = 0
  - `cap_addr`, `trace_end` = 0
  - prescaler and counters = 0
- All outputs registered.
- `capture_go` at cycle N:
  - `we`=1 at N+1.
  - First `cap_en` at N+1.
  - Subsequent strobes every 2^decimator cycles.
- `cap_addr` valid in the same cycle as `cap_en`.
- `trig_in` sampled at cycle T in ARMED → `triggered`=1 at T+1.
- Final POST tick at cycle F → `capture_done`=1 and updated `trace_end` at F+1. No `cap_en` at F+1.
- Reset mid-capture returns to IDLE immediately. No strobe is issued after `rst` asserts.

## Configuration
- `CAPTURE_DECIMATE_EN` defined:
  - 16-bit prescaler compiled in.
  - Tick when prescaler == 2^decimator - 1, then prescaler ← 0.
  - `decimator` is sampled on `capture_go` and held for the capture.
- Undefined:
  - No prescaler; tick every cycle.
  - `decimator` unused.

## Test plan
- **Reset during capture.** Reset, then `capture_go` with trig_pos=100, decimator=0, `trig_in` low.
  - Exactly 284 strobes at addr 0..283, then `armed`=1.
  - `trig_in` never asserted → remains ARMED, pointer wraps 383 → 0.
  - Assert `rst` → all outputs 0 next edge.
- **Full trigger sequence.** Continue the ARMED capture; pulse `trig_in` while the pointer = 10.
  - 100 further strobes.
  - `capture_done`=1, `trace_end`=110 (10 written on trigger cycle, then 11..110).
  - `we`=0.
- **trig_pos clamp and zero.**
  - trig_pos=400 → clamped to 383; ARMED after 1 sample.
  - trig_pos=0 → trigger goes to DONE next cycle, `trace_end` = last written address.
- **Dump interlock and restart.**
  - `capture_go` with `dump_busy`=1 in IDLE → ignored, `we` stays 0.
  - `capture_go` in POST → pointer restarts at 0, `triggered`=0, `armed`=0.
- **Decimation (`CAPTURE_DECIMATE_EN`).**
  - decimator=3 → `cap_en` every 8 cycles, first at N+1.
  - Changing `decimator` mid-capture has no effect.
- **Back-to-back captures.** Second `capture_go` in DONE → `capture_done` drops next cycle; `trace_end` keeps its old value until the new DONE.
